// File: rtl/decode_stage.sv
// Decode stage: one-entry holding register between fetch and operand read.
// Splits the held instruction into fields, tracks in-flight destination
// registers in a scoreboard and withholds issue on RAW/WAW hazards.
module decode_stage #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 4,
  parameter int IMMBITS   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 i_valid,
  input  logic [DBITS-1:0]     i_inst,
  input  logic [DBITS-1:0]     i_pc,
  output logic                 o_ready,
  input  logic                 flush,
  input  logic                 ds_ready,
  output logic                 o_valid,
  output logic [3:0]           o_opcode,
  output logic [REGNOBITS-1:0] o_rd,
  output logic [REGNOBITS-1:0] o_rs,
  output logic [REGNOBITS-1:0] o_rt,
  output logic [IMMBITS-1:0]   o_imm,
  output logic                 o_wr,
  output logic [DBITS-1:0]     o_pc,
  input  logic                 wb_valid,
  input  logic [REGNOBITS-1:0] wb_rd
);

  localparam int NREGS  = 1 << REGNOBITS;
  localparam int OP_LSB = DBITS - 4;
  localparam int RD_LSB = OP_LSB - REGNOBITS;
  localparam int RS_LSB = RD_LSB - REGNOBITS;
  localparam int RT_LSB = RS_LSB - REGNOBITS;

  logic             hv_r;
  logic [DBITS-1:0] inst_r;
  logic [DBITS-1:0] pc_r;
  logic [NREGS-1:0] sb_r;
  logic [NREGS-1:0] sb_next_s;
  logic             hazard_s;
  logic             issue_s;
  logic             capture_s;

  // A register is pending when its scoreboard bit is set; r0 never is.
  function automatic logic pending(input logic [NREGS-1:0] sb,
                                   input logic [REGNOBITS-1:0] r);
    return (r != {REGNOBITS{1'b0}}) && sb[r];
  endfunction

  // Field outputs are plain slices of the held instruction word.
  assign o_opcode = inst_r[OP_LSB +: 4];
  assign o_rd     = inst_r[RD_LSB +: REGNOBITS];
  assign o_rs     = inst_r[RS_LSB +: REGNOBITS];
  assign o_rt     = inst_r[RT_LSB +: REGNOBITS];
  assign o_imm    = inst_r[IMMBITS-1:0];
  assign o_pc     = pc_r;
  assign o_wr     = ~o_opcode[3] & (o_rd != {REGNOBITS{1'b0}});

  // Hazard check: rs/rt always; rd when it is read (opcode[3]) or written (WAW).
  always_comb begin
    hazard_s = 1'b0;
    if (hv_r) begin
      hazard_s = pending(sb_r, o_rs) | pending(sb_r, o_rt);
      if (o_opcode[3] | o_wr) begin
        hazard_s = hazard_s | pending(sb_r, o_rd);
      end else begin
        hazard_s = hazard_s;
      end
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign o_valid   = hv_r & ~hazard_s & ~flush;
  assign issue_s   = o_valid & ds_ready;
  assign o_ready   = ~hv_r | issue_s;
  assign capture_s = i_valid & o_ready & ~flush;

  // Scoreboard next state: writeback clear first, then issue set so set wins.
  always_comb begin
    sb_next_s = sb_r;
    if (wb_valid) begin
      sb_next_s[wb_rd] = 1'b0;
    end else begin
      sb_next_s = sb_next_s;
    end
    if (issue_s & o_wr) begin
      sb_next_s[o_rd] = 1'b1;
    end else begin
      sb_next_s = sb_next_s;
    end
    sb_next_s[0] = 1'b0;
  end

  // Holding register and scoreboard state; flush drops the entry only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hv_r   <= 1'b0;
      inst_r <= {DBITS{1'b0}};
      pc_r   <= {DBITS{1'b0}};
      sb_r   <= {NREGS{1'b0}};
    end else begin
      sb_r <= sb_next_s;
      if (flush) begin
        hv_r <= 1'b0;
      end else if (capture_s) begin
        hv_r   <= 1'b1;
        inst_r <= i_inst;
        pc_r   <= i_pc;
      end else if (issue_s) begin
        hv_r <= 1'b0;
      end
    end
  end

endmodule
